// File: rtl/rvga_debugbus_mon_pkg.sv
// Shared rvga decode-field types plus the debug-bus monitor
// trace record layout and counter map.
package rvga_debugbus_mon_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_OP     = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rvga_opcode_e;

    // R..J are 0..5; 6 and 7 are unused encodings
    typedef enum logic [2:0] {
        IT_R = 3'd0,
        IT_I = 3'd1,
        IT_S = 3'd2,
        IT_B = 3'd3,
        IT_U = 3'd4,
        IT_J = 3'd5
    } rvga_inst_type_e;

    typedef enum logic [2:0] {
        BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } rvga_brop_e;

    typedef enum logic [2:0] {
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU
    } rvga_ldop_e;

    typedef enum logic [1:0] {
        ST_SB, ST_SH, ST_SW
    } rvga_strop_e;

    typedef enum logic [3:0] {
        AR_ADD, AR_SUB, AR_SLL, AR_SLT, AR_SLTU,
        AR_XOR, AR_SRL, AR_SRA, AR_OR, AR_AND
    } rvga_artop_e;

    typedef struct packed {
        rvga_opcode_e    opcode;
        rvga_inst_type_e inst_type;
        rvga_brop_e      brop;
        rvga_ldop_e      ldop;
        rvga_strop_e     strop;
        rvga_artop_e     artop;
    } rvga_trace_rec_t;

    localparam int RVGA_TRACE_W = $bits(rvga_trace_rec_t);

    localparam logic [3:0] MON_TOTAL  = 4'd0;
    localparam logic [3:0] MON_R      = 4'd1;
    localparam logic [3:0] MON_I      = 4'd2;
    localparam logic [3:0] MON_S      = 4'd3;
    localparam logic [3:0] MON_B      = 4'd4;
    localparam logic [3:0] MON_U      = 4'd5;
    localparam logic [3:0] MON_J      = 4'd6;
    localparam logic [3:0] MON_DROP   = 4'd7;
    localparam logic [3:0] MON_LOAD   = 4'd8;
    localparam logic [3:0] MON_STORE  = 4'd9;
    localparam logic [3:0] MON_BRANCH = 4'd10;
    localparam logic [3:0] MON_NUM    = 4'd11;
    localparam int         MON_CNT    = 11;

endpackage

// File: rtl/rvga_debugbus_mon_fifo.sv
// Registered synchronous FIFO, no fall-through; dout is
// zero while empty. Push while full succeeds only with a pop.
module rvga_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rvga_debugbus_mon.sv
// Debug-bus monitor: saturating per-class instruction counters
// with a one-cycle read port, plus a trace FIFO of decoded records.
module rvga_debugbus_mon
    import rvga_debugbus_mon_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    dbg_valid_i,
    input  rvga_opcode_e            dbg_opcode_i,
    input  rvga_inst_type_e         dbg_inst_type_i,
    input  rvga_brop_e              dbg_brop_i,
    input  rvga_ldop_e              dbg_ldop_i,
    input  rvga_strop_e             dbg_strop_i,
    input  rvga_artop_e             dbg_artop_i,
    input  logic                    clr_i,
    input  logic                    rd_en_i,
    input  logic [3:0]              rd_addr_i,
    output logic [CNT_W-1:0]        rd_data_o,
    output logic                    rd_valid_o,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [RVGA_TRACE_W-1:0] trace_data_o,
    output logic                    trace_ovf_o
);

    logic [CNT_W-1:0]   cnt_q [MON_CNT];
    logic [MON_CNT-1:0] inc;
    logic [CNT_W-1:0]   rd_mux;
    logic               rec_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;
    rvga_trace_rec_t    rec;

    assign rec = '{
        opcode:    dbg_opcode_i,
        inst_type: dbg_inst_type_i,
        brop:      dbg_brop_i,
        ldop:      dbg_ldop_i,
        strop:     dbg_strop_i,
        artop:     dbg_artop_i
    };

    // clr wins: the colliding instruction is neither counted nor pushed
    assign rec_valid     = dbg_valid_i && !clr_i;
    assign trace_valid_o = !fifo_empty;
    assign pop           = trace_valid_o && trace_ready_i;
    assign drop          = rec_valid && fifo_full && !pop;

    rvga_sync_fifo #(
        .WIDTH (RVGA_TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .clr   (clr_i),
        .push  (rec_valid),
        .pop   (pop),
        .din   (rec),
        .dout  (trace_data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        inc = '0;
        if (rec_valid) begin
            inc[MON_TOTAL] = 1'b1;
            case (dbg_inst_type_i)
                IT_R:    inc[MON_R] = 1'b1;
                IT_I:    inc[MON_I] = 1'b1;
                IT_S:    inc[MON_S] = 1'b1;
                IT_B:    inc[MON_B] = 1'b1;
                IT_U:    inc[MON_U] = 1'b1;
                IT_J:    inc[MON_J] = 1'b1;
                default: ;
            endcase
            inc[MON_LOAD]   = (dbg_opcode_i == OP_LOAD);
            inc[MON_STORE]  = (dbg_opcode_i == OP_STORE);
            inc[MON_BRANCH] = (dbg_opcode_i == OP_BRANCH);
        end
        inc[MON_DROP] = drop;
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr_i < MON_NUM) begin
            rd_mux = cnt_q[rd_addr_i];
        end
    end

    // Reads sample the pre-update counters, so they see pre-clear values
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < MON_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            rd_data_o   <= '0;
            rd_valid_o  <= 1'b0;
            trace_ovf_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= rd_mux;
            end
            if (clr_i) begin
                for (int i = 0; i < MON_CNT; i++) begin
                    cnt_q[i] <= '0;
                end
                trace_ovf_o <= 1'b0;
            end else begin
                for (int i = 0; i < MON_CNT; i++) begin
                    if (inc[i] && (cnt_q[i] != '1)) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
                if (drop) begin
                    trace_ovf_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvga_debugbus_mon.sv
// Self-checking bench for rvga_debugbus_mon: directed tables and
// sequences plus random traffic against a queue-based model.
module tb_rvga_debugbus_mon;
    import rvga_debugbus_mon_pkg::*;

    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int MAXC  = 15;

    logic                    clk = 1'b0;
    logic                    reset_i = 1'b1;
    logic                    dbg_valid_i = 1'b0;
    rvga_opcode_e            dbg_opcode_i = OP_OP;
    rvga_inst_type_e         dbg_inst_type_i = IT_R;
    rvga_brop_e              dbg_brop_i = BR_BEQ;
    rvga_ldop_e              dbg_ldop_i = LD_LB;
    rvga_strop_e             dbg_strop_i = ST_SB;
    rvga_artop_e             dbg_artop_i = AR_ADD;
    logic                    clr_i = 1'b0;
    logic                    rd_en_i = 1'b0;
    logic [3:0]              rd_addr_i = '0;
    logic [CW-1:0]           rd_data_o;
    logic                    rd_valid_o;
    logic                    trace_valid_o;
    logic                    trace_ready_i = 1'b0;
    logic [RVGA_TRACE_W-1:0] trace_data_o;
    logic                    trace_ovf_o;

    always #5 clk = ~clk;

    rvga_debugbus_mon #(
        .CNT_W       (CW),
        .TRACE_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .dbg_valid_i     (dbg_valid_i),
        .dbg_opcode_i    (dbg_opcode_i),
        .dbg_inst_type_i (dbg_inst_type_i),
        .dbg_brop_i      (dbg_brop_i),
        .dbg_ldop_i      (dbg_ldop_i),
        .dbg_strop_i     (dbg_strop_i),
        .dbg_artop_i     (dbg_artop_i),
        .clr_i           (clr_i),
        .rd_en_i         (rd_en_i),
        .rd_addr_i       (rd_addr_i),
        .rd_data_o       (rd_data_o),
        .rd_valid_o      (rd_valid_o),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_data_o    (trace_data_o),
        .trace_ovf_o     (trace_ovf_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int              m_cnt [11];
    rvga_trace_rec_t m_q [$];
    bit              m_ovf;
    bit              m_rdv;
    int              m_rd;

    typedef struct {
        logic [3:0] addr;
        int         exp;
    } rd_vec_t;

    rd_vec_t tbl [8];
    rvga_trace_rec_t recs [10];
    rvga_trace_rec_t got [$];
    rvga_trace_rec_t xrec;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void bump(input int i);
        m_cnt[i] = (m_cnt[i] < MAXC) ? m_cnt[i] + 1 : MAXC;
    endfunction

    function automatic void model(input bit rst, input bit v,
                                  input bit c, input bit re,
                                  input logic [3:0] a, input bit rdy,
                                  input rvga_trace_rec_t r);
        bit pop;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q.delete();
            m_ovf = 0;
            m_rdv = 0;
            m_rd  = 0;
            return;
        end
        m_rdv = re;
        if (re) m_rd = (a <= 4'd10) ? m_cnt[a] : 0;
        if (c) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q.delete();
            m_ovf = 0;
            return;
        end
        pop = (m_q.size() > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (v) begin
            if (m_q.size() < DEPTH) m_q.push_back(r);
            else begin
                bump(7);
                m_ovf = 1;
            end
            bump(0);
            if (int'(r.inst_type) <= 5) bump(1 + int'(r.inst_type));
            if (r.opcode == OP_LOAD) bump(8);
            if (r.opcode == OP_STORE) bump(9);
            if (r.opcode == OP_BRANCH) bump(10);
        end
    endfunction

    task automatic step(input bit rst, input bit v, input bit c,
                        input bit re, input logic [3:0] a,
                        input bit rdy, input rvga_trace_rec_t r);
        rvga_trace_rec_t etd;
        reset_i         = rst;
        dbg_valid_i     = v;
        dbg_opcode_i    = r.opcode;
        dbg_inst_type_i = r.inst_type;
        dbg_brop_i      = r.brop;
        dbg_ldop_i      = r.ldop;
        dbg_strop_i     = r.strop;
        dbg_artop_i     = r.artop;
        clr_i           = c;
        rd_en_i         = re;
        rd_addr_i       = a;
        trace_ready_i   = rdy;
        @(posedge clk);
        model(rst, v, c, re, a, rdy, r);
        #1;
        etd = (m_q.size() > 0) ? m_q[0] : '0;
        chk("rd_valid", rd_valid_o, m_rdv);
        if (m_rdv) chk("rd_data", rd_data_o, m_rd);
        chk("trace_valid", trace_valid_o, m_q.size() > 0);
        chk("trace_data", trace_data_o, etd);
        chk("trace_ovf", trace_ovf_o, m_ovf);
    endtask

    task automatic push(input rvga_trace_rec_t r, input bit rdy);
        step(0, 1, 0, 0, 4'd0, rdy, r);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 4'd0, rdy, '0);
    endtask

    task automatic rd(input logic [3:0] a, input bit rdy);
        step(0, 0, 0, 1, a, rdy, '0);
    endtask

    task automatic clr();
        step(0, 0, 1, 0, 4'd0, 1, '0);
    endtask

    function automatic rvga_trace_rec_t mk(input rvga_opcode_e op,
                                           input rvga_inst_type_e it,
                                           input int tag);
        rvga_trace_rec_t r;
        r.opcode    = op;
        r.inst_type = it;
        r.brop      = rvga_brop_e'(3'(tag % 6));
        r.ldop      = rvga_ldop_e'(3'(tag % 5));
        r.strop     = rvga_strop_e'(2'(tag % 3));
        r.artop     = rvga_artop_e'(4'(tag));
        return r;
    endfunction

    function automatic rvga_trace_rec_t rand_rec();
        rvga_opcode_e ops [5];
        rvga_trace_rec_t r;
        ops = '{OP_OP, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM};
        r.opcode    = ops[$urandom_range(0, 4)];
        r.inst_type = rvga_inst_type_e'(3'($urandom_range(0, 7)));
        r.brop      = rvga_brop_e'(3'($urandom_range(0, 5)));
        r.ldop      = rvga_ldop_e'(3'($urandom_range(0, 4)));
        r.strop     = rvga_strop_e'(2'($urandom_range(0, 2)));
        r.artop     = rvga_artop_e'(4'($urandom_range(0, 9)));
        return r;
    endfunction

    initial begin
        tbl = '{
            '{4'd0, 6}, '{4'd1, 3}, '{4'd2, 2}, '{4'd4, 1},
            '{4'd8, 2}, '{4'd10, 1}, '{4'd9, 0}, '{4'd7, 0}
        };

        step(1, 0, 0, 0, 4'd0, 0, '0);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_trace_valid", trace_valid_o, 0);
        chk("reset_trace_data", trace_data_o, 0);
        chk("reset_ovf", trace_ovf_o, 0);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a), 0);
            chk("reset_read_valid", rd_valid_o, 1);
            chk("reset_read_data", rd_data_o, 0);
        end
        idle(0);
        chk("rd_valid_pulse", rd_valid_o, 0);

        for (int i = 0; i < 3; i++) push(mk(OP_OP, IT_R, i), 1);
        for (int i = 0; i < 2; i++) push(mk(OP_LOAD, IT_I, i), 1);
        push(mk(OP_BRANCH, IT_B, 0), 1);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, 1);
            chk("class_count", rd_data_o, tbl[i].exp);
        end

        clr();
        for (int i = 0; i < 10; i++) begin
            recs[i] = mk(OP_OP, IT_R, i);
            push(recs[i], 0);
        end
        chk("ovf_set", trace_ovf_o, 1);
        rd(MON_DROP, 0);
        chk("drop_count", rd_data_o, 2);
        rd(MON_TOTAL, 0);
        chk("total_10", rd_data_o, 10);
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", trace_valid_o, 1);
            chk("drain_order", trace_data_o, recs[k]);
            idle(1);
        end
        chk("drain_empty", trace_valid_o, 0);
        clr();
        chk("ovf_cleared", trace_ovf_o, 0);

        clr();
        for (int i = 0; i < 8; i++) push(recs[i], 0);
        xrec = mk(OP_STORE, IT_S, 12);
        push(xrec, 1);
        rd(MON_DROP, 0);
        chk("full_pushpop_drop", rd_data_o, 0);
        chk("full_pushpop_ovf", trace_ovf_o, 0);
        got.delete();
        for (int n = 0; n < 20 && trace_valid_o; n++) begin
            got.push_back(trace_data_o);
            idle(1);
        end
        chk("full_occupancy", got.size(), 8);
        if (got.size() == 8) begin
            chk("full_first", got[0], recs[1]);
            chk("full_last", got[7], xrec);
        end

        clr();
        for (int i = 0; i < 16; i++) push(mk(OP_IMM, IT_I, i), 1);
        rd(MON_TOTAL, 1);
        chk("sat_total", rd_data_o, 15);
        push(mk(OP_IMM, IT_I, 0), 1);
        rd(MON_TOTAL, 1);
        chk("sat_hold", rd_data_o, 15);
        rd(MON_I, 1);
        chk("sat_i", rd_data_o, 15);

        clr();
        push(mk(OP_OP, rvga_inst_type_e'(3'd6), 1), 1);
        rd(MON_TOTAL, 1);
        chk("bad_type_total", rd_data_o, 1);
        rd(4'd12, 1);
        chk("addr12_zero", rd_data_o, 0);

        clr();
        for (int i = 0; i < 5; i++) push(mk(OP_OP, IT_R, i), 0);
        step(0, 1, 1, 1, MON_TOTAL, 0, mk(OP_LOAD, IT_I, 3));
        chk("clr_read_pre", rd_data_o, 5);
        chk("clr_fifo_empty", trace_valid_o, 0);
        chk("clr_ovf", trace_ovf_o, 0);
        rd(MON_TOTAL, 0);
        chk("clr_total", rd_data_o, 0);
        rd(MON_LOAD, 0);
        chk("clr_no_count", rd_data_o, 0);

        for (int i = 0; i < 3; i++) push(mk(OP_OP, IT_R, i), 0);
        step(1, 0, 0, 1, MON_TOTAL, 0, '0);
        chk("midreset_rdv", rd_valid_o, 0);
        chk("midreset_fifo", trace_valid_o, 0);

        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0,
                 rand_rec());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
